// File: rtl/ines_loader_if.sv
// Byte-stream handshake between the NIOS-side source (master) and the iNES loader (slave).
interface ines_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ines_loader.sv
// Streaming iNES loader: header parse, trainer skip, PRG write with 16 KB mirroring, CHR write.
// Define INES_LOADER_CHR_EN to drive the CHR write port; otherwise CHR bytes are consumed and dropped.
module ines_loader (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    ines_loader_if.slave s,
    output logic [15:0]  prgmr_addr,
    output logic [7:0]   prgmr_data,
    output logic         prgmr_wren,
    output logic [12:0]  chr_addr,
    output logic [7:0]   chr_data,
    output logic         chr_wren,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code,
    output logic [7:0]   mapper,
    output logic         mirroring,
    output logic [7:0]   prg_banks,
    output logic [7:0]   chr_banks
);
    typedef enum logic [2:0] {
        IDLE, HDR, TRAINER, PRG, PRG_MIRROR, CHR, DONE, ERR
    } state_t;

    state_t      state;
    logic [3:0]  hdr_cnt;
    logic [8:0]  trn_cnt;
    logic [14:0] prg_i;
    logic [12:0] chr_j;
    logic [3:0]  map_lo;
    logic [3:0]  map_hi;
    logic        trainer_en;
    logic        mirror_q;
    logic        accept;
    logic        prg_last;

    function automatic logic [7:0] magic(input logic [1:0] k);
        case (k)
            2'd0:    magic = 8'h4E;
            2'd1:    magic = 8'h45;
            2'd2:    magic = 8'h53;
            default: magic = 8'h1A;
        endcase
    endfunction

    assign s.s_ready = (state == HDR) || (state == TRAINER) || (state == PRG) || (state == CHR);
    assign accept    = s.s_valid & s.s_ready;
    assign busy      = s.s_ready || (state == PRG_MIRROR);
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign mapper    = {map_hi, map_lo};
    assign mirroring = mirror_q;
    // Last offset is $3FFF for one bank, $7FFF for two.
    assign prg_last  = (prg_i == {prg_banks[1], 14'h3FFF});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hdr_cnt    <= '0;
            trn_cnt    <= '0;
            prg_i      <= '0;
            chr_j      <= '0;
            map_lo     <= '0;
            map_hi     <= '0;
            trainer_en <= 1'b0;
            mirror_q   <= 1'b0;
            prg_banks  <= '0;
            chr_banks  <= '0;
            err_code   <= '0;
            prgmr_addr <= '0;
            prgmr_data <= '0;
            prgmr_wren <= 1'b0;
        end else begin
            prgmr_wren <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= HDR;
                        hdr_cnt    <= '0;
                        trn_cnt    <= '0;
                        prg_i      <= '0;
                        chr_j      <= '0;
                        map_lo     <= '0;
                        map_hi     <= '0;
                        trainer_en <= 1'b0;
                        mirror_q   <= 1'b0;
                        prg_banks  <= '0;
                        chr_banks  <= '0;
                        err_code   <= '0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr_cnt != 4'hF) hdr_cnt <= hdr_cnt + 4'd1;
                        if (hdr_cnt < 4'd4) begin
                            if (s.s_data != magic(hdr_cnt[1:0])) begin
                                state    <= ERR;
                                err_code <= 2'd1;
                            end
                        end else if (hdr_cnt == 4'd4) begin
                            prg_banks <= s.s_data;
                            if (s.s_data == 8'd0 || s.s_data > 8'd2) begin
                                state    <= ERR;
                                err_code <= 2'd2;
                            end
                        end else if (hdr_cnt == 4'd5) begin
                            chr_banks <= s.s_data;
                            if (s.s_data > 8'd1) begin
                                state    <= ERR;
                                err_code <= 2'd3;
                            end
                        end else if (hdr_cnt == 4'd6) begin
                            map_lo     <= s.s_data[7:4];
                            trainer_en <= s.s_data[2];
                            mirror_q   <= s.s_data[0];
                        end else if (hdr_cnt == 4'd7) begin
                            map_hi <= s.s_data[7:4];
                        end else if (hdr_cnt == 4'hF) begin
                            state <= trainer_en ? TRAINER : PRG;
                        end
                    end
                end
                TRAINER: begin
                    if (accept) begin
                        if (trn_cnt == '1) state <= PRG;
                        else               trn_cnt <= trn_cnt + 9'd1;
                    end
                end
                PRG: begin
                    if (accept) begin
                        prgmr_addr <= {1'b1, prg_i};
                        prgmr_data <= s.s_data;
                        prgmr_wren <= 1'b1;
                        // One-bank images defer the offset step and exit to the mirror cycle.
                        if (!prg_banks[1])  state <= PRG_MIRROR;
                        else if (prg_last)  state <= chr_banks[0] ? CHR : DONE;
                        else                prg_i <= prg_i + 15'd1;
                    end
                end
                PRG_MIRROR: begin
                    prgmr_addr <= {2'b11, prg_i[13:0]};
                    prgmr_wren <= 1'b1;
                    if (prg_last) begin
                        state <= chr_banks[0] ? CHR : DONE;
                    end else begin
                        state <= PRG;
                        prg_i <= prg_i + 15'd1;
                    end
                end
                CHR: begin
                    if (accept) begin
                        if (chr_j == '1) state <= DONE;
                        else             chr_j <= chr_j + 13'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INES_LOADER_CHR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chr_addr <= '0;
            chr_data <= '0;
            chr_wren <= 1'b0;
        end else begin
            chr_wren <= (state == CHR) && accept;
            if ((state == CHR) && accept) begin
                chr_addr <= chr_j;
                chr_data <= s.s_data;
            end
        end
    end
`else
    assign chr_addr = '0;
    assign chr_data = '0;
    assign chr_wren = 1'b0;
`endif
endmodule
